// File: rtl/led_pwm_ctrl_if.sv
// CPU-side valid/ready bus between the SoC decoder and the LED peripheral.
// The decoder/CPU drives the request fields; the peripheral returns the ack and read data.
interface led_pwm_ctrl_if;
  logic        sel;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED driver: register file behind a one-cycle valid/ready handshake,
// a prescaled 8-bit PWM, a programmable blink timer and a registered LED output stage.
module led_pwm_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned BLINK_W  = 24,
  parameter logic [7:0]  RST_LED  = 8'h00
) (
  input  logic           clk,
  input  logic           rstn,
  led_pwm_ctrl_if.slave  bus,
  output logic [7:0]     LED
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  localparam int unsigned        PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]    PS_MAX     = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]    PS_ONE     = PS_W'(1'b1);
  localparam logic [PS_W-1:0]    PS_ZERO    = PS_W'(1'b0);
  localparam logic [BLINK_W-1:0] BLINK_RST  = BLINK_W'(32'd1000);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1'b1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(1'b0);

  // Merge the strobed bytes of new_val over old_val.
  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_val[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [0:0]         r_state;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic [2:0]         r_ctrl;
  logic [7:0]         r_led_val;
  logic [7:0]         r_duty;
  logic [BLINK_W-1:0] r_blink;
  logic [PS_W-1:0]    r_prescale;
  logic [7:0]         r_pwm_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [7:0]         r_led;

  logic [2:0]         w_idx;
  logic               w_accept;
  logic               w_write;
  logic               w_blink_wr;
  logic [31:0]        w_rd_mux;
  logic [31:0]        w_blink_ext;
  logic [31:0]        w_wr_word;
  logic               w_ps_wrap;
  logic [BLINK_W-1:0] w_blink_last;
  logic               w_blink_hit;
  logic               w_pwm_on;
  logic [7:0]         w_led_next;
  logic               w_unused;

  assign w_idx        = bus.mem_addr[4:2];
  assign w_accept     = (r_state == ST_IDLE) && bus.sel && bus.mem_valid && !r_ready;
  assign w_write      = w_accept && (bus.mem_wstrb != 4'b0000);
  assign w_wr_word    = byte_merge(w_rd_mux, bus.mem_wdata, bus.mem_wstrb);
  assign w_blink_wr   = w_write && (w_idx == 3'd3);
  assign w_ps_wrap    = (r_prescale == PS_MAX);
  // A zero half-period behaves like one: toggle on every clock.
  assign w_blink_last = (r_blink == BLINK_ZERO) ? BLINK_ZERO : (r_blink - BLINK_ONE);
  assign w_blink_hit  = (r_blink_cnt == w_blink_last);
  assign w_pwm_on     = (r_pwm_cnt < r_duty);
  assign w_unused     = ^{bus.mem_addr[1:0], w_wr_word};

  // Register read view; also the base word that strobed writes merge into.
  always_comb begin
    w_rd_mux                  = 32'd0;
    w_blink_ext               = 32'd0;
    w_blink_ext[BLINK_W-1:0]  = r_blink;
    case (w_idx)
      3'd0:    w_rd_mux = {29'd0, r_ctrl};
      3'd1:    w_rd_mux = {24'd0, r_led_val};
      3'd2:    w_rd_mux = {24'd0, r_duty};
      3'd3:    w_rd_mux = w_blink_ext;
      3'd4:    w_rd_mux = {23'd0, r_blink_phase, r_pwm_cnt};
      default: w_rd_mux = 32'd0;
    endcase
  end

  // Handshake FSM: accept in IDLE, hold ready for the single ACK cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ACK;
            r_ready <= 1'b1;
            r_rdata <= w_write ? 32'd0 : w_rd_mux;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
        end
      endcase
    end
  end

  // Writable registers update on the accepting edge, i.e. with mem_ready rising.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ctrl    <= 3'd0;
      r_led_val <= RST_LED;
      r_duty    <= 8'h80;
      r_blink   <= BLINK_RST;
    end else if (w_write) begin
      case (w_idx)
        3'd0:    r_ctrl    <= w_wr_word[2:0];
        3'd1:    r_led_val <= w_wr_word[7:0];
        3'd2:    r_duty    <= w_wr_word[7:0];
        3'd3:    r_blink   <= w_wr_word[BLINK_W-1:0];
        default: r_ctrl    <= r_ctrl;
      endcase
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  // Free-running PWM timebase, independent of EN.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_prescale <= PS_ZERO;
      r_pwm_cnt  <= 8'd0;
    end else if (w_ps_wrap) begin
      r_prescale <= PS_ZERO;
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
    end else begin
      r_prescale <= r_prescale + PS_ONE;
    end
  end

  // Blink timer; a BLINK write restarts the half-period from phase 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_blink_cnt   <= BLINK_ZERO;
      r_blink_phase <= 1'b0;
    end else if (w_blink_wr) begin
      r_blink_cnt   <= BLINK_ZERO;
      r_blink_phase <= 1'b0;
    end else if (w_blink_hit) begin
      r_blink_cnt   <= BLINK_ZERO;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLINK_ONE;
    end
  end

  // Output mode select from the current register/timer state.
  always_comb begin
    w_led_next = 8'h00;
    if (r_ctrl[0]) begin
      case (r_ctrl[2:1])
        2'd0:    w_led_next = r_led_val;
        2'd1:    w_led_next = r_led_val & {8{w_pwm_on}};
        2'd2:    w_led_next = r_led_val & {8{r_blink_phase}};
        2'd3:    w_led_next = r_led_val & {8{w_pwm_on & r_blink_phase}};
        default: w_led_next = 8'h00;
      endcase
    end else begin
      w_led_next = 8'h00;
    end
  end

  // Registered LED pins.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_led <= 8'h00;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign LED           = r_led;

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Memory-mapped LED peripheral inside the SoC. It takes CPU bus writes and reads on a valid/ready handshake and drives the board-level LED[7:0] pins. It supports static, PWM-dimmed and blinking output modes, with a prescaled PWM counter and a programmable blink timer. It sits between the SoC's bus decoder and the top-level LED output.

Parameters:
PRESCALE, 4, clk cycles per PWM counter tick (>=1)
BLINK_W, 24, width of the blink half-period register/counter
RST_LED, 8'h00, LED_VAL reset value

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
sel  input  1  bus decoder select for this peripheral
mem_valid  input  1  bus request valid
mem_addr  input  5  byte offset within peripheral; bits [4:2] used
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write strobes; 0 = read
mem_ready  output  1  one-cycle acknowledge
mem_rdata  output  32  read data, valid while mem_ready=1
LED  output  8  LED pins, registered

Behaviour:
- Reset (rstn=0 at a clk edge):
  - CTRL=0, LED_VAL=RST_LED, DUTY=8'h80, BLINK=24'd1000.
  - pwm_cnt, prescaler, blink_cnt and blink_phase = 0.
  - mem_ready=0, mem_rdata=0, LED=0.
  - Reset overrides any in-flight request; no ack is issued for it.
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [2:1] MODE (0 static, 1 pwm, 2 blink, 3 pwm+blink).
  - 0x04 LED_VAL[7:0].
  - 0x08 DUTY[7:0].
  - 0x0C BLINK[BLINK_W-1:0].
  - 0x10 STATUS, read-only: {blink_phase, pwm_cnt}.
  - Offsets 0x14-0x1C read 0; writes to them are ignored.
- Handshake FSM, states IDLE and ACK:
  - IDLE: sel & mem_valid & !mem_ready -> capture request, go to ACK.
  - ACK: mem_ready=1 for exactly one cycle, then IDLE.
  - Latency: 1 cycle from accepted valid to ready.
  - Write: the register updates on the same edge that raises mem_ready; bytes are written per mem_wstrb, and unused high bits are ignored.
  - Read: mem_rdata is loaded with the register value on the same edge and forced to 0 whenever mem_ready=0.
  - Back-to-back requests: the master holds valid through ready, so the cycle after ACK is always IDLE. The next request is accepted no earlier than 1 cycle after ready, giving a 2-cycle minimum spacing.
- PWM:
  - The prescaler counts 0..PRESCALE-1; on wrap, pwm_cnt increments.
  - pwm_cnt is 8-bit and wraps 255->0.
  - pwm_on = (pwm_cnt < DUTY). DUTY=0 gives always off; DUTY=255 gives on 255/256.
  - Counters run regardless of EN.
- Blink:
  - blink_cnt increments every clk. When blink_cnt == BLINK-1, it clears and blink_phase toggles.
  - BLINK=0 is treated as 1 (toggle every cycle).
  - A write to BLINK clears blink_cnt and blink_phase on the same edge.
- Output: LED is registered, 1 cycle after its inputs.
  - EN=0 -> 0.
  - MODE0 -> LED_VAL.
  - MODE1 -> LED_VAL & {8{pwm_on}}.
  - MODE2 -> LED_VAL & {8{blink_phase}}.
  - MODE3 -> LED_VAL & {8{pwm_on & blink_phase}}.
- A register write takes effect on LED one cycle after mem_ready.

Test Plan:
1. Reset then release at 10ns, no bus traffic -> LED=8'h00, mem_ready=0, reads 0x00/0x04/0x08/0x0C return 0, RST_LED, 0x80, 1000.
2. Write 0x04=0x5A, then CTRL=0x1 (wstrb=4'hF) -> each mem_ready is high exactly 1 cycle after valid; LED=0x5A one cycle after the CTRL ack; read 0x04 returns 0x0000005A.
3. LED_VAL=0xFF, DUTY=0x40, CTRL=0x3, PRESCALE=4 -> over one 1024-cycle PWM period, LED=0xFF for exactly 256 cycles; DUTY=0 -> LED stays 0; DUTY=0xFF -> LED low for exactly 4 cycles per period.
4. BLINK=10, CTRL=0x5, LED_VAL=0x0F -> LED toggles 0x00/0x0F every 10 cycles. Rewrite BLINK=3 mid-phase -> phase restarts at 0 and toggles every 3 cycles. BLINK=0 -> toggles every cycle.
5. Write with wstrb=4'b0010 to 0x04 (data 0xAB00) -> LED_VAL unchanged (byte 1 is outside the field). Write to 0x18 -> acked, no state change, and a read of 0x18 returns 0.
6. Assert rstn=0 for one cycle while a write is in ACK -> no ack issued, all registers return to reset values, LED=0 on the next cycle.
